// File: rtl/btn_intr_pkg.sv
// Shared types and helpers for the push-button interrupt generator.
// Pure declarations: no latency, no flow control.
package btn_intr_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [MAX_SRC-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_intr_gen_if.sv
// Button inputs, processor interrupt handshake and status outputs of btn_intr_gen.
// Wiring only: no latency, no backpressure.
interface btn_intr_gen_if #(
    parameter int N_SRC = 4
);
    localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] btn_raw;
    logic             intr_ack;
    logic             irq;
    logic [IDW-1:0]   irq_id;
    logic [N_SRC-1:0] pending;
    logic             overflow;

    modport slave (
        input  btn_raw,
        input  intr_ack,
        output irq,
        output irq_id,
        output pending,
        output overflow
    );

    modport master (
        output btn_raw,
        output intr_ack,
        input  irq,
        input  irq_id,
        input  pending,
        input  overflow
    );
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF sync, debounce, rise pulse. Level toggles 2+DEBOUNCE_CYCLES
// edges after a stable change; rise is combinational off the level. No backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
        end
    endgenerate

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt   <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/btn_intr_gen.sv
// Debounced buttons -> pending latch -> single level irq, retired by intr_ack rising edge.
// irq one edge after pending set; no backpressure, repeat edges on a pending source set overflow.
module btn_intr_gen
    import btn_intr_pkg::*;
#(
    parameter int N_SRC           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLDOFF_CYCLES  = 4
) (
    input  logic           sys_clk,
    input  logic           ext_rst,
    btn_intr_gen_if.slave  bus
);
    localparam int IDW      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int HOLD_EFF = (HOLDOFF_CYCLES < 1) ? 1 : HOLDOFF_CYCLES;
    localparam int HW       = $clog2(HOLD_EFF + 1);

    generate
        if (N_SRC < 1 || N_SRC > MAX_SRC) begin : g_bad_nsrc
            $error("btn_intr_gen: N_SRC must be in 1..8");
        end
    endgenerate

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] clr;
    logic             overflow_q;
    logic             ovf_set;
    logic             ack_q;
    logic             ack_rise;
    state_t           state_q;
    state_t           state_d;
    logic             irq_q;
    logic             irq_d;
    logic [IDW-1:0]   irq_id_q;
    logic [IDW-1:0]   irq_id_d;
    logic [HW-1:0]    hcnt_q;
    logic [HW-1:0]    hcnt_d;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (sys_clk),
            .rst_n (ext_rst),
            .raw   (bus.btn_raw[i]),
            .rise  (rise[i])
        );
    end

    assign ack_rise = bus.intr_ack & ~ack_q;

    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        hcnt_d   = hcnt_q;
        clr      = '0;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    irq_id_d = IDW'(lowest_set(MAX_SRC'(pending_q)));
                    irq_d    = 1'b1;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (ack_rise) begin
                    clr     = N_SRC'(1) << irq_id_q;
                    irq_d   = 1'b0;
                    hcnt_d  = HW'(HOLD_EFF);
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                irq_d = 1'b0;
                if (hcnt_q <= HW'(1)) begin
                    hcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_q - HW'(1);
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        // A new edge outranks a same-cycle clear, and is then not a repeat.
        pending_d = (pending_q & ~clr) | rise;
        ovf_set   = |(rise & pending_q & ~clr);
    end

    always_ff @(posedge sys_clk or negedge ext_rst) begin
        if (!ext_rst) begin
            state_q    <= IDLE;
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
            hcnt_q     <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            irq_id_q   <= irq_id_d;
            hcnt_q     <= hcnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_q | ovf_set;
            ack_q      <= bus.intr_ack;
        end
    end

    assign bus.irq      = irq_q;
    assign bus.irq_id   = irq_id_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule
